// File: rtl/serie_pkg.sv
// Shared definitions for the serial transmitter and its companion
// serial-to-parallel converter: frame states and the data width.
package serie_pkg;

   localparam int N_BITS_DATO = 8;

   typedef enum logic [2:0] {
      REPOSO,
      INICIO,
      DATOS,
      PARIDAD,
      PARADA
   } estado_t;

   // Even parity: the extra bit makes the total count of ones even.
   function automatic logic paridad_par(input logic [N_BITS_DATO-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/generador_baudios.sv
// Bit-period timer. Counts clk cycles inside one serial bit while enabled and
// flags the interesting positions of the count. Flags that feed registered
// outputs are raised one cycle early so the registered copy lands on time.
module generador_baudios #(
   parameter int CLKS_POR_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic habilitar,
   output logic tick,
   output logic medio,
   output logic pre_tick
);

   localparam int ANCHO = $clog2(CLKS_POR_BIT);
   localparam logic [ANCHO-1:0] ULTIMO     = ANCHO'(CLKS_POR_BIT - 1);
   localparam logic [ANCHO-1:0] PENULTIMO  = ANCHO'(CLKS_POR_BIT - 2);
   localparam logic [ANCHO-1:0] ANTE_MEDIO = ANCHO'(CLKS_POR_BIT / 2 - 1);

   logic [ANCHO-1:0] cnt;

   // Cycle counter within the bit: held at zero while idle, wraps on the last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!habilitar) begin
         cnt <= '0;
      end else if (cnt == ULTIMO) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ANCHO'(1);
      end
   end

   // tick marks the last cycle of the bit; medio and pre_tick mark the cycle
   // before the mid-point and the cycle before the last one respectively.
   assign tick     = habilitar && (cnt == ULTIMO);
   assign medio    = habilitar && (cnt == ANTE_MEDIO);
   assign pre_tick = habilitar && (cnt == PENULTIMO);

endmodule

// File: rtl/transmisor_serie.sv
// Framed parallel-to-serial transmitter: start bit, 8 data bits LSB first,
// optional even parity, stop bit. Also produces the mid-bit sample strobe
// used by the downstream shift register.
module transmisor_serie
   import serie_pkg::*;
#(
   parameter int CLKS_POR_BIT = 16,
   parameter bit PARIDAD_EN   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_BITS_DATO-1:0] dato_in,
   input  logic                   cargar,
   output logic                   listo,
   output logic                   dato,
   output logic                   bit_control,
   output logic                   ocupado,
   output logic                   fin_trama
);

   estado_t                estado;
   logic [N_BITS_DATO-1:0] shreg;
   logic [2:0]             idx;
   logic                   habilitar;
   logic                   tick;
   logic                   medio;
   logic                   pre_tick;

   // The bit timer only runs while a frame is on the line.
   assign habilitar = (estado != REPOSO);

   generador_baudios #(
      .CLKS_POR_BIT(CLKS_POR_BIT)
   ) u_baudios (
      .clk      (clk),
      .rst_n    (rst_n),
      .habilitar(habilitar),
      .tick     (tick),
      .medio    (medio),
      .pre_tick (pre_tick)
   );

   // Frame sequencer with all outputs registered; strobes are computed from
   // the early timer flags so they are high during the intended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado      <= REPOSO;
         shreg       <= '0;
         idx         <= '0;
         dato        <= 1'b1;
         listo       <= 1'b1;
         ocupado     <= 1'b0;
         bit_control <= 1'b0;
         fin_trama   <= 1'b0;
      end else begin
         bit_control <= (estado == DATOS) && medio;
         fin_trama   <= (estado == PARADA) && pre_tick;
         case (estado)
            REPOSO: begin
               if (cargar) begin
                  shreg   <= dato_in;
                  estado  <= INICIO;
                  dato    <= 1'b0;
                  listo   <= 1'b0;
                  ocupado <= 1'b1;
               end
            end
            INICIO: begin
               if (tick) begin
                  estado <= DATOS;
                  idx    <= '0;
                  dato   <= shreg[0];
               end
            end
            DATOS: begin
               if (tick) begin
                  if (idx == 3'd7) begin
                     if (PARIDAD_EN) begin
                        estado <= PARIDAD;
                        dato   <= paridad_par(shreg);
                     end else begin
                        estado <= PARADA;
                        dato   <= 1'b1;
                     end
                  end else begin
                     idx  <= idx + 3'd1;
                     dato <= shreg[idx + 3'd1];
                  end
               end
            end
            PARIDAD: begin
               if (tick) begin
                  estado <= PARADA;
                  dato   <= 1'b1;
               end
            end
            PARADA: begin
               if (tick) begin
                  estado  <= REPOSO;
                  dato    <= 1'b1;
                  listo   <= 1'b1;
                  ocupado <= 1'b0;
               end
            end
            default: begin
               estado <= REPOSO;
               dato   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmisor_serie.sv
// Bench for transmisor_serie: one instance without parity and one with parity,
// both at 4 clk per bit, checked cycle by cycle against a frame model built
// from the bit list of each byte.
module tb_transmisor_serie;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cargar0, cargar1;
   logic [7:0] dato_in0, dato_in1;
   logic       listo0, dato0, bc0, ocupado0, fin0;
   logic       listo1, dato1, bc1, ocupado1, fin1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   transmisor_serie #(.CLKS_POR_BIT(C), .PARIDAD_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .dato_in(dato_in0), .cargar(cargar0),
      .listo(listo0), .dato(dato0), .bit_control(bc0), .ocupado(ocupado0),
      .fin_trama(fin0)
   );

   transmisor_serie #(.CLKS_POR_BIT(C), .PARIDAD_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .dato_in(dato_in1), .cargar(cargar1),
      .listo(listo1), .dato(dato1), .bit_control(bc1), .ocupado(ocupado1),
      .fin_trama(fin1)
   );

   task automatic check_output(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int sel, input logic c, input logic [7:0] b);
      if (sel == 0) begin
         cargar0  = c;
         dato_in0 = b;
      end else begin
         cargar1  = c;
         dato_in1 = b;
      end
   endtask

   task automatic read_outs(input int sel, output logic d, output logic bc,
                            output logic l, output logic o, output logic f);
      if (sel == 0) begin
         d = dato0; bc = bc0; l = listo0; o = ocupado0; f = fin0;
      end else begin
         d = dato1; bc = bc1; l = listo1; o = ocupado1; f = fin1;
      end
   endtask

   // Sends one byte and checks every cycle of the frame against the model:
   // the line is the bit list (start, data LSB first, parity, stop) stretched
   // C clocks per bit, the strobe sits at C/2 of each data bit, and fin_trama
   // is the last clock. The strobed samples must rebuild the byte.
   task automatic run_frame(input int sel, input logic [7:0] b, input bit hold,
                            input logic [7:0] next_b, input bit inject);
      logic       bits[$];
      logic       d, bc, l, o, f;
      logic [7:0] rx;
      int         len, w, strobes, bitn;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (sel == 1) bits.push_back(^b);
      bits.push_back(1'b1);
      len = bits.size() * C;

      w = 0;
      read_outs(sel, d, bc, l, o, f);
      while (l !== 1'b1 && w < 200) begin
         step();
         w++;
         read_outs(sel, d, bc, l, o, f);
      end
      check_output($sformatf("listo before %h", b), l, 1'b1);

      apply_stimulus(sel, 1'b1, b);
      step();
      if (hold) apply_stimulus(sel, 1'b1, next_b);
      else apply_stimulus(sel, 1'b0, b);

      strobes = 0;
      rx = '0;
      for (int j = 0; j < len; j++) begin
         bitn = j / C;
         read_outs(sel, d, bc, l, o, f);
         check_output($sformatf("dato %h j=%0d", b, j), d, bits[bitn]);
         check_output($sformatf("bit_control %h j=%0d", b, j), bc,
                      (bitn >= 1 && bitn <= 8 && (j % C) == C / 2));
         check_output($sformatf("fin_trama %h j=%0d", b, j), f, (j == len - 1));
         check_output($sformatf("listo %h j=%0d", b, j), l, 1'b0);
         check_output($sformatf("ocupado %h j=%0d", b, j), o, 1'b1);
         if (bc === 1'b1) begin
            if (strobes < 8) rx[strobes] = d;
            strobes++;
         end
         if (inject && j == 5) apply_stimulus(sel, 1'b1, 8'h3C);
         if (inject && j == 12) apply_stimulus(sel, 1'b0, 8'h3C);
         step();
      end

      read_outs(sel, d, bc, l, o, f);
      check_output($sformatf("listo after %h", b), l, 1'b1);
      check_output($sformatf("ocupado after %h", b), o, 1'b0);
      check_output($sformatf("idle dato after %h", b), d, 1'b1);
      check_output($sformatf("fin after %h", b), f, 1'b0);
      check_int($sformatf("strobes %h", b), strobes, 8);
      check_int($sformatf("rx byte %h", b), int'(rx), int'(b));
   endtask

   initial begin
      logic       d, bc, l, o, f;
      logic [7:0] rb;
      int         sel;

      rst_n = 1'b0;
      apply_stimulus(0, 1'b0, 8'h00);
      apply_stimulus(1, 1'b0, 8'h00);

      // Reset state of both instances, then released and held
      repeat (3) step();
      for (int s = 0; s < 2; s++) begin
         read_outs(s, d, bc, l, o, f);
         check_output($sformatf("reset dato %0d", s), d, 1'b1);
         check_output($sformatf("reset listo %0d", s), l, 1'b1);
         check_output($sformatf("reset ocupado %0d", s), o, 1'b0);
         check_output($sformatf("reset bit_control %0d", s), bc, 1'b0);
         check_output($sformatf("reset fin %0d", s), f, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         read_outs(0, d, bc, l, o, f);
         check_output("post reset dato", d, 1'b1);
         check_output("post reset listo", l, 1'b1);
      end

      $display("[TB] frames A5 (no parity), 07 and 00 (parity)");
      run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
      run_frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
      run_frame(1, 8'h00, 1'b0, 8'h00, 1'b0);

      $display("[TB] load request while busy is ignored");
      run_frame(0, 8'hC3, 1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 6; k++) begin
         read_outs(0, d, bc, l, o, f);
         check_output($sformatf("no second frame dato k=%0d", k), d, 1'b1);
         check_output($sformatf("no second frame listo k=%0d", k), l, 1'b1);
         step();
      end

      $display("[TB] cargar held high: back-to-back 81, 18");
      run_frame(0, 8'h81, 1'b1, 8'h18, 1'b0);
      run_frame(0, 8'h18, 1'b0, 8'h00, 1'b0);

      $display("[TB] reset in the middle of data bit 3");
      apply_stimulus(0, 1'b1, 8'hE7);
      step();
      apply_stimulus(0, 1'b0, 8'hE7);
      repeat (4 * C + 1) step();
      read_outs(0, d, bc, l, o, f);
      check_output("dato before abort", d, 1'b0);
      rst_n = 1'b0;
      #1;
      read_outs(0, d, bc, l, o, f);
      check_output("abort dato", d, 1'b1);
      check_output("abort listo", l, 1'b1);
      check_output("abort ocupado", o, 1'b0);
      check_output("abort fin", f, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step();
         read_outs(0, d, bc, l, o, f);
         check_output("abort fin held", f, 1'b0);
      end
      rst_n = 1'b1;
      step();
      run_frame(0, 8'h5A, 1'b0, 8'h00, 1'b0);

      $display("[TB] random frames");
      for (int k = 0; k < 6; k++) begin
         sel = int'($urandom_range(0, 1));
         rb = 8'($urandom);
         repeat ($urandom_range(0, 3)) step();
         run_frame(sel, rb, 1'b0, 8'h00, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
